// File: rtl/s298_bist_pkg.sv
// Shared types and constants for the s298 BIST controller: FSM states,
// LFSR/MISR geometry and the bit positions of the CUT response bus.
package s298_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } st_t;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  localparam int MISR_W = 16;
  localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

  // CUT_RESP = {G66, G67, G117, G118, G132, G133}
  localparam int RESP_W    = 6;
  localparam int RESP_G133 = 0;
  localparam int RESP_G132 = 1;
  localparam int RESP_G118 = 2;
  localparam int RESP_G117 = 3;
  localparam int RESP_G67  = 4;
  localparam int RESP_G66  = 5;

  // Fibonacci step: shift left, feedback is the XOR of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/s298_bist_ctrl_if.sv
// BIST controller bus: test control/status plus the CUT stimulus and response.
// slave = controller side, master = harness/CUT side.
interface s298_bist_ctrl_if;

  logic                              START;
  logic [s298_bist_pkg::RESP_W-1:0]  CUT_RESP;
  logic                              CUT_G0;
  logic                              CUT_G1;
  logic                              CUT_G2;
  logic                              BUSY;
  logic                              DONE;
  logic                              PASS;
  logic [s298_bist_pkg::MISR_W-1:0]  SIGNATURE;

  modport master (
    output START, CUT_RESP,
    input  CUT_G0, CUT_G1, CUT_G2, BUSY, DONE, PASS, SIGNATURE
  );

  modport slave (
    input  START, CUT_RESP,
    output CUT_G0, CUT_G1, CUT_G2, BUSY, DONE, PASS, SIGNATURE
  );

endinterface

// File: rtl/s298_misr.sv
// Multiple-input signature register, internal-XOR form; one cycle per capture.
// clr has priority over en; the register holds when neither is asserted.
module s298_misr #(
  parameter int            W    = 16,
  parameter logic [W-1:0]  POLY = W'(16'h1021)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sig
);

  logic [W-1:0] nxt;

  always_comb begin
    nxt = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= nxt;
    end
  end

endmodule

// File: rtl/s298_bist_ctrl.sv
// BIST controller for s298: LFSR stimulus on G0..G2, MISR compaction of the six
// CUT outputs, golden-signature compare. START is only honoured in IDLE/DONE.
module s298_bist_ctrl #(
  parameter int          PATTERN_COUNT = 255,
  parameter int          INIT_CYCLES   = 4,
  parameter logic [7:0]  LFSR_SEED     = 8'h01,
  parameter logic [15:0] GOLDEN_SIG    = 16'h0000
) (
  input  logic             CK,
  input  logic             RST,
  s298_bist_ctrl_if.slave  bus
);

  import s298_bist_pkg::*;

  localparam int CNT_MAX = (PATTERN_COUNT > INIT_CYCLES) ? PATTERN_COUNT : INIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  INIT_LOAD = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RUN_LOAD  = CNT_W'(PATTERN_COUNT - 1);
  localparam logic [LFSR_W-1:0] SEED      = (LFSR_SEED == '0) ? 8'h01 : LFSR_SEED;

  st_t               state;
  logic [LFSR_W-1:0] lfsr;
  logic [CNT_W-1:0]  cnt;
  logic              busy_q;
  logic              done_q;

  logic              start_ok;
  logic              misr_clr;
  logic              misr_en;
  logic [MISR_W-1:0] misr_din;
  logic [MISR_W-1:0] sig;
  logic              g0;
  logic              g1;
  logic              g2;

  assign start_ok = bus.START && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      lfsr   <= SEED;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.START) begin
            state  <= ST_INIT;
            lfsr   <= SEED;
            cnt    <= INIT_LOAD;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        ST_INIT: begin
          if (cnt == '0) begin
            state <= ST_RUN;
            cnt   <= RUN_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RUN: begin
          lfsr <= lfsr_next(lfsr);
          if (cnt == '0) begin
            state <= ST_FLUSH;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_FLUSH: begin
          state  <= ST_DONE;
          cnt    <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // The CUT registers its outputs, so the response to pattern k arrives one
  // cycle later: skip the first RUN cycle and pick up the last one in FLUSH.
  assign misr_clr = start_ok;
  assign misr_en  = ((state == ST_RUN) && (cnt != RUN_LOAD)) || (state == ST_FLUSH);
  assign misr_din = {{(MISR_W - RESP_W){1'b0}}, bus.CUT_RESP};

  s298_misr #(
    .W    (MISR_W),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk (CK),
    .rst (RST),
    .clr (misr_clr),
    .en  (misr_en),
    .din (misr_din),
    .sig (sig)
  );

  // G0 is the CUT's synchronous clear, so it stays asserted outside RUN/FLUSH.
  always_comb begin
    g0 = 1'b1;
    g1 = 1'b0;
    g2 = 1'b0;
    case (state)
      ST_RUN: begin
        g0 = &lfsr[2:0];
        g1 = lfsr[3];
        g2 = lfsr[4];
      end
      ST_FLUSH: begin
        g0 = 1'b0;
      end
      default: begin
        g0 = 1'b1;
      end
    endcase
  end

  assign bus.CUT_G0    = g0;
  assign bus.CUT_G1    = g1;
  assign bus.CUT_G2    = g2;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.PASS      = done_q && (sig == GOLDEN_SIG);
  assign bus.SIGNATURE = sig;

endmodule

// File: doc/s298_bist_ctrl.md
# s298_bist_ctrl

Built-in self-test controller for the s298 sequential benchmark. It drives the CUT's three primary inputs (G0, G1, G2) from a pseudo-random pattern generator and compacts the CUT's six primary outputs into a signature. It compares that signature against a golden value and reports pass or fail. It wraps one s298 instance in the DFT test harness: s298_bist_ctrl outputs feed the CUT inputs, and the CUT outputs feed back into s298_bist_ctrl.

## Interface
Parameters:
- PATTERN_COUNT, 255: number of random patterns applied; must be ≥ 1.
- INIT_CYCLES, 4: cycles the CUT is held cleared (G0=1) before patterns; must be ≥ 1.
- LFSR_SEED, 8'h01: LFSR load value; 8'h00 is replaced by 8'h01.
- GOLDEN_SIG, 16'h0000: expected final MISR value, set from a fault-free simulation.

Ports:
- CK  in  1: clock, rising edge.
- RST  in  1: reset, asynchronous, active-high.
- START  in  1: begin a test run; sampled only in IDLE and DONE.
- CUT_RESP  in  6: CUT outputs, ordered {G66,G67,G117,G118,G132,G133}, with bit 0 = G133.
- CUT_G0  out  1: CUT G0, which acts as the CUT's synchronous clear.
- CUT_G1  out  1: CUT G1.
- CUT_G2  out  1: CUT G2.
- BUSY  out  1: high in INIT, RUN and FLUSH.
- DONE  out  1: high in the DONE state.
- PASS  out  1: SIGNATURE == GOLDEN_SIG; valid only while DONE=1, and 0 otherwise.
- SIGNATURE  out  16: current MISR contents.

## Operation
FSM states are IDLE, INIT, RUN, FLUSH and DONE.

State behaviour:
- **IDLE:** CUT_G0=1, CUT_G1=0, CUT_G2=0, so the CUT is kept cleared. START=1 loads the LFSR with the seed, clears the MISR and the counter, and moves to INIT.
- **INIT:** drives CUT_G0=1, G1=0, G2=0 for INIT_CYCLES cycles, then moves to RUN.
- **RUN:** lasts PATTERN_COUNT cycles, then moves to FLUSH. Each cycle:
  - CUT_G0 = lfsr[0]&lfsr[1]&lfsr[2], giving roughly 1/8 clear density.
  - CUT_G1 = lfsr[3].
  - CUT_G2 = lfsr[4].
  - The LFSR advances.
  - The MISR captures CUT_RESP on every RUN cycle except the first.
- **FLUSH:** one cycle. CUT inputs are driven to 0/0/0, the MISR captures the final response, then the FSM moves to DONE.
- **DONE:** DONE=1 and PASS is valid; all outputs hold. START=1 re-enters INIT with the same initialisation as from IDLE. CUT_G0=1 in DONE.

Datapath:
- **LFSR:** 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- **MISR:** 16-bit, x^16+x^12+x^5+1. next = ({misr[14:0],1'b0} ^ (misr[15] ? 16'h1021 : 0)) ^ {10'b0, CUT_RESP}. It holds its value outside the capture cycles.
- **Capture count:** exactly PATTERN_COUNT responses are compacted, PATTERN_COUNT−1 in RUN plus 1 in FLUSH. This accounts for the CUT's one-cycle register latency.
- **Counter:** one shared down-counter, $clog2(max(PATTERN_COUNT, INIT_CYCLES)+1) bits wide. It is reloaded on every state entry.
- **Output sourcing:** CUT_G* are decoded from registered state and the LFSR only; there is no combinational path from START or CUT_RESP.

## Timing
- **Reset values:** state=IDLE, lfsr=LFSR_SEED, misr=0, counter=0. Outputs: BUSY=0, DONE=0, PASS=0, SIGNATURE=0, CUT_G0=1, CUT_G1=0, CUT_G2=0.
- **Reset mid-run:** RST in any state aborts immediately to the reset values; no partial result is reported.
- **START latency:** START sampled at edge E gives BUSY=1 after E. DONE rises after edge E+INIT_CYCLES+PATTERN_COUNT+1, which is 260 cycles with the defaults.
- **START while busy:** START while BUSY=1 is ignored. START held high in DONE restarts on the next edge.
- **SIGNATURE updates:** SIGNATURE changes only on capture edges. PASS and DONE change together.

## Structure
- Package s298_bist_pkg holds:
  - the state enum;
  - the LFSR width (8) and tap mask 8'hB8;
  - the MISR width (16) and polynomial 16'h1021;
  - the CUT_RESP bit-order constants.
- Sub-module s298_misr, a parameterised-width MISR with enable and synchronous clear, is instantiated once.
- The LFSR, counter and FSM live in the top module.

## Test plan
- **Short run with tied-off response:** INIT_CYCLES=1, PATTERN_COUNT=5, seed 8'h01, CUT_RESP tied 0, GOLDEN_SIG=0 → DONE at START+7, SIGNATURE=16'h0000, PASS=1.
- **LFSR sequence on CUT inputs:** same setup → RUN LFSR values are 01, 02, 04, 08, 11. (G1,G2) is (0,0), (0,0), (0,0), (1,0), (0,1), and CUT_G0 is 0 on every RUN cycle.
- **Constant-response compaction:** PATTERN_COUNT=2, CUT_RESP=6'h01 → MISR steps 16'h0001 then 16'h0003. With GOLDEN_SIG=16'h0003, PASS=1; with 16'h0004, PASS=0.
- **Reset and START handling:** RST asserted mid-RUN → all outputs at reset values in the same cycle, and IDLE holds CUT_G0=1. START pulsed while BUSY → no effect on the DONE time.
- **End-to-end with the real CUT:** full defaults with an s298 instance → two back-to-back runs give identical SIGNATURE. A forced stuck-at-0 on CUT_RESP[5] changes SIGNATURE and gives PASS=0.
